// File: rtl/regbank_wport.sv
// regbank_wport
//   Receiving end of the writeback -> register-bank write path. Write requests
//   are queued in a small in-order buffer and retired one per cycle into a
//   register array (r15 = PC) plus a committed CPSR. Reads from decode see the
//   newest buffered value for their register, so in-flight writes are never
//   hidden. The fetch stage has its own PC write strobe and PC output.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   triggerInw   write request valid; writer holds it until accepted
//   dataIn       write data
//   addrw        destination register
//   cpsrIn       CPSR value that commits together with the write
//   readyOutW    buffer not full (combinational from the entry count)
//   holdIn       1 = suspend retirement, the buffer only fills
//   triggerInr   read request
//   addrr        register to read
//   readyOutR    read data valid, one-cycle pulse the edge after a request
//   dataOut      read data, holds its last value between reads
//   pcWe         PC write strobe from fetch
//   pcIn         PC value from fetch
//   pcOut        r15 array value, registered
//   cpsrOut      committed CPSR (retired writes only)
//   pendingOut   number of buffered writes, 0..DEPTH

module regbank_wport #(
    parameter  int DW    = 32,
    parameter  int NREG  = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(NREG),
    localparam int PW    = $clog2(DEPTH),
    localparam int CNT_W = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             triggerInw,
    input  logic [DW-1:0]    dataIn,
    input  logic [AW-1:0]    addrw,
    input  logic [DW-1:0]    cpsrIn,
    output logic             readyOutW,
    input  logic             holdIn,
    input  logic             triggerInr,
    input  logic [AW-1:0]    addrr,
    output logic             readyOutR,
    output logic [DW-1:0]    dataOut,
    input  logic             pcWe,
    input  logic [DW-1:0]    pcIn,
    output logic [DW-1:0]    pcOut,
    output logic [DW-1:0]    cpsrOut,
    output logic [CNT_W-1:0] pendingOut
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

    logic [DW-1:0]    regs [NREG];
    logic [DW-1:0]    cpsr_q;

    logic [AW-1:0]    fifo_addr [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DW-1:0]    fifo_cpsr [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [AW-1:0]    head_addr;
    logic             retire_pc;
    logic [PW-1:0]    slot_idx;
    logic [DW-1:0]    read_val;

    // A full buffer refuses a push even if it pops on the same edge: the slot
    // freed by the pop only becomes visible through readyOutW a cycle later.
    assign readyOutW  = (count < CNT_W'(DEPTH));
    assign push       = triggerInw && readyOutW;
    assign pop        = !holdIn && (count != '0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign retire_pc  = pop && (head_addr == PC_IDX);
    assign pendingOut = count;
    assign cpsrOut    = cpsr_q;

    // Forwarding: walk the live entries oldest to newest and keep the last
    // match, so the newest buffered write to the register wins. The entry
    // retiring this edge is the oldest, so it is only chosen when nothing
    // younger matches. A write arriving on this same edge is not visible yet.
    always_comb begin
        read_val = regs[addrr];
        slot_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_idx = rd_ptr + PW'(k);
            if ((CNT_W'(k) < count) && (fifo_addr[slot_idx] == addrr)) begin
                read_val = fifo_data[slot_idx];
            end
        end
    end

    // NOTE: the buffer payload has no reset; entries are only ever read when
    // the count says they are live, and the pointers/count are reset instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addrw;
            fifo_data[wr_ptr] <= dataIn;
            fifo_cpsr[wr_ptr] <= cpsrIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Architectural state. A retire to r15 and a fetch PC write on the same
    // edge resolve in favour of the retire; the fetch write is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            cpsr_q <= '0;
        end else begin
            if (pop) begin
                regs[head_addr] <= fifo_data[rd_ptr];
                cpsr_q          <= fifo_cpsr[rd_ptr];
            end
            if (pcWe && !retire_pc) begin
                regs[PC_IDX] <= pcIn;
            end
        end
    end

    // Output registers: read port and PC. pcOut samples the array, so it
    // follows any r15 write one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readyOutR <= 1'b0;
            dataOut   <= '0;
            pcOut     <= '0;
        end else begin
            readyOutR <= triggerInr;
            if (triggerInr) dataOut <= read_val;
            pcOut <= regs[PC_IDX];
        end
    end

endmodule

// File: tb/tb_regbank_wport.sv
module tb_regbank_wport;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        triggerInw;
    logic [31:0] dataIn;
    logic [3:0]  addrw;
    logic [31:0] cpsrIn;
    logic        readyOutW;
    logic        holdIn;
    logic        triggerInr;
    logic [3:0]  addrr;
    logic        readyOutR;
    logic [31:0] dataOut;
    logic        pcWe;
    logic [31:0] pcIn;
    logic [31:0] pcOut;
    logic [31:0] cpsrOut;
    logic [2:0]  pendingOut;

    regbank_wport #(.DW(32), .NREG(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .triggerInw (triggerInw),
        .dataIn     (dataIn),
        .addrw      (addrw),
        .cpsrIn     (cpsrIn),
        .readyOutW  (readyOutW),
        .holdIn     (holdIn),
        .triggerInr (triggerInr),
        .addrr      (addrr),
        .readyOutR  (readyOutR),
        .dataOut    (dataOut),
        .pcWe       (pcWe),
        .pcIn       (pcIn),
        .pcOut      (pcOut),
        .cpsrOut    (cpsrOut),
        .pendingOut (pendingOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of pending writes plus plain architectural state.
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] cpsr;
    } wr_t;

    wr_t         q[$];
    logic [31:0] m_regs [16];
    logic [31:0] m_cpsr;
    logic [31:0] m_pc;
    logic [31:0] m_dout;
    logic        m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_cpsr = '0;
        m_pc   = '0;
        m_dout = '0;
        m_rdy  = 1'b0;
    endtask

    task automatic idle_inputs();
        triggerInw = 1'b0; dataIn = '0; addrw = '0; cpsrIn = '0;
        holdIn = 1'b0; triggerInr = 1'b0; addrr = '0; pcWe = 1'b0; pcIn = '0;
    endtask

    // One clock: advance the model from the current inputs, take the edge,
    // then compare every output against the model.
    task automatic cycle();
        logic        full;
        logic        do_push;
        logic        hit_pc;
        logic [31:0] pc_next;
        wr_t         e;
        full    = (q.size() == DEPTH);
        do_push = triggerInw && !full;
        m_rdy   = triggerInr;
        if (triggerInr) begin
            m_dout = m_regs[addrr];
            foreach (q[i]) if (q[i].addr == addrr) m_dout = q[i].data;
        end
        pc_next = m_regs[15];
        hit_pc  = 1'b0;
        if (!holdIn && q.size() > 0) begin
            e = q.pop_front();
            m_regs[e.addr] = e.data;
            m_cpsr = e.cpsr;
            hit_pc = (e.addr == 4'd15);
        end
        if (pcWe && !hit_pc) m_regs[15] = pcIn;
        if (do_push) q.push_back('{addr: addrw, data: dataIn, cpsr: cpsrIn});
        m_pc = pc_next;
        @(posedge clk);
        #1;
        check("model_readyOutW", 32'(readyOutW), 32'(q.size() < DEPTH));
        check("model_pendingOut", 32'(pendingOut), 32'(q.size()));
        check("model_readyOutR", 32'(readyOutR), 32'(m_rdy));
        check("model_dataOut", dataOut, m_dout);
        check("model_pcOut", pcOut, m_pc);
        check("model_cpsrOut", cpsrOut, m_cpsr);
    endtask

    task automatic read_reg(input logic [3:0] a, input logic [31:0] exp, input string name);
        triggerInr = 1'b1;
        addrr      = a;
        cycle();
        triggerInr = 1'b0;
        check(name, dataOut, exp);
    endtask

    task automatic push_req(input logic [3:0] a, input logic [31:0] d, input logic [31:0] c);
        triggerInw = 1'b1; addrw = a; dataIn = d; cpsrIn = c;
        cycle();
        triggerInw = 1'b0;
    endtask

    typedef struct {
        logic        tw;
        logic [3:0]  aw;
        logic [31:0] dw;
        logic        hold;
        logic        tr;
        logic [3:0]  ar;
        logic [2:0]  e_pend;
        logic        e_rdy;
        logic [31:0] e_dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic accepted;
        logic acc_now;

        // Hand-computed vectors starting from an empty buffer with r11 = r5 = 0.
        vecs[0] = '{1'b1, 4'd11, 32'hDEADBEEF, 1'b0, 1'b1, 4'd11, 3'd1, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd11, 3'd0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'd5,  32'h11,       1'b1, 1'b1, 4'd5,  3'd1, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 4'd5,  32'h22,       1'b1, 1'b1, 4'd5,  3'd2, 1'b1, 32'h11};
        vecs[4] = '{1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 4'd0,  3'd2, 1'b0, 32'h11};
        vecs[5] = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd5,  3'd1, 1'b1, 32'h22};
        vecs[6] = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd5,  3'd0, 1'b1, 32'h22};
        vecs[7] = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd11, 3'd0, 1'b1, 32'hDEADBEEF};

        idle_inputs();
        model_clear();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state and a read of r3.
        check("rst_readyOutW", 32'(readyOutW), 32'd1);
        check("rst_pendingOut", 32'(pendingOut), 32'd0);
        check("rst_readyOutR", 32'(readyOutR), 32'd0);
        read_reg(4'd3, 32'h0, "rst_read_r3");

        // Single write, commit, read back.
        triggerInw = 1'b1; addrw = 4'd3; dataIn = 32'hDEADBEEF; cpsrIn = 32'h60000010;
        cycle();
        triggerInw = 1'b0;
        check("wr_pending_1", 32'(pendingOut), 32'd1);
        cycle();
        check("wr_pending_0", 32'(pendingOut), 32'd0);
        check("wr_cpsrOut", cpsrOut, 32'h60000010);
        read_reg(4'd3, 32'hDEADBEEF, "wr_read_r3");
        check("wr_readyOutR", 32'(readyOutR), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            triggerInw = vecs[i].tw; addrw = vecs[i].aw; dataIn = vecs[i].dw; cpsrIn = '0;
            holdIn = vecs[i].hold; triggerInr = vecs[i].tr; addrr = vecs[i].ar;
            cycle();
            check($sformatf("vec%0d_pending", i), 32'(pendingOut), 32'(vecs[i].e_pend));
            check($sformatf("vec%0d_readyOutR", i), 32'(readyOutR), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_dataOut", i), dataOut, vecs[i].e_dout);
        end
        idle_inputs();

        // Fill under hold, refuse a fifth write, forward the newest r1.
        holdIn = 1'b1;
        push_req(4'd1, 32'd1, 32'hA1);
        push_req(4'd1, 32'd2, 32'hA2);
        push_req(4'd2, 32'd3, 32'hA3);
        push_req(4'd4, 32'd4, 32'hA4);
        check("hold_full_readyOutW", 32'(readyOutW), 32'd0);
        check("hold_full_pending", 32'(pendingOut), 32'd4);
        push_req(4'd1, 32'd99, 32'hA5);
        check("hold_5th_ignored", 32'(pendingOut), 32'd4);
        read_reg(4'd1, 32'd2, "hold_fwd_r1");
        holdIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("drain_pending_%0d", i), 32'(pendingOut), 32'(3 - i));
        end
        check("drain_cpsrOut", cpsrOut, 32'hA4);
        read_reg(4'd1, 32'd2, "drain_r1");
        read_reg(4'd2, 32'd3, "drain_r2");
        read_reg(4'd4, 32'd4, "drain_r4");

        // Retire to r15 and fetch PC write on the same edge: retire wins.
        holdIn = 1'b1;
        push_req(4'd15, 32'h100, 32'hB0);
        holdIn = 1'b0; pcWe = 1'b1; pcIn = 32'h200;
        cycle();
        pcWe = 1'b0;
        cycle();
        check("pc_retire_wins", pcOut, 32'h100);
        pcWe = 1'b1; pcIn = 32'h300;
        cycle();
        pcWe = 1'b0;
        check("pc_lag_one_edge", pcOut, 32'h100);
        cycle();
        check("pc_fetch_write", pcOut, 32'h300);

        // Full buffer while draining: a held request is taken one cycle after the pop.
        holdIn = 1'b1;
        push_req(4'd6, 32'hA, 32'hC1);
        push_req(4'd7, 32'hB, 32'hC2);
        push_req(4'd6, 32'hC, 32'hC3);
        push_req(4'd8, 32'hD, 32'hC4);
        holdIn = 1'b0;
        triggerInw = 1'b1; addrw = 4'd6; dataIn = 32'hE; cpsrIn = 32'hC5;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 10) begin
            acc_now = readyOutW;
            cycle();
            waited++;
            if (acc_now) accepted = 1'b1;
        end
        triggerInw = 1'b0;
        check("full_accepted", 32'(accepted), 32'd1);
        check("full_accept_latency", 32'(waited), 32'd2);
        check("full_pending_after", 32'(pendingOut), 32'd3);
        for (int i = 0; i < 3; i++) cycle();
        check("full_drained", 32'(pendingOut), 32'd0);
        check("full_cpsr_last", cpsrOut, 32'hC5);
        read_reg(4'd6, 32'hE, "full_order_r6");
        read_reg(4'd7, 32'hB, "full_order_r7");
        read_reg(4'd8, 32'hD, "full_order_r8");

        // Reset with writes still buffered.
        holdIn = 1'b1;
        push_req(4'd9, 32'h99, 32'hD1);
        push_req(4'd10, 32'hAA, 32'hD2);
        push_req(4'd3, 32'hBB, 32'hD3);
        check("midrst_pending_before", 32'(pendingOut), 32'd3);
        reset = 1'b0;
        #1;
        check("midrst_pending", 32'(pendingOut), 32'd0);
        check("midrst_cpsrOut", cpsrOut, 32'h0);
        check("midrst_pcOut", pcOut, 32'h0);
        check("midrst_readyOutW", 32'(readyOutW), 32'd1);
        check("midrst_dataOut", dataOut, 32'h0);
        reset = 1'b1;
        model_clear();
        idle_inputs();
        read_reg(4'd3, 32'h0, "midrst_r3_cleared");
        read_reg(4'd6, 32'h0, "midrst_r6_cleared");
        read_reg(4'd9, 32'h0, "midrst_r9_not_committed");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            triggerInw = 1'($urandom_range(0, 1));
            addrw      = 4'($urandom_range(0, 15));
            dataIn     = $urandom;
            cpsrIn     = $urandom;
            holdIn     = ($urandom_range(0, 3) == 0);
            triggerInr = 1'($urandom_range(0, 1));
            addrr      = 4'($urandom_range(0, 15));
            pcWe       = ($urandom_range(0, 7) == 0);
            pcIn       = $urandom;
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        for (int r = 0; r < 16; r++) read_reg(4'(r), m_regs[r], $sformatf("final_r%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
